// File: rtl/id_ex_register_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_register_if
//  Description : ID->EX pipeline bus. Carries the decoded instruction from
//                the ID stage, the registered copy presented to EX, and the
//                hold / flush / stall pipeline controls.
//  Revision    : 1.0  initial release
// ============================================================================
interface id_ex_register_if;

  // Pipeline control
  logic        hold;
  logic        flush;
  logic        stall;

  // Decoded instruction from ID
  logic [1:0]  id_pcsrc;
  logic        id_regwrite;
  logic [1:0]  id_regdst;
  logic        id_memread;
  logic        id_memwrite;
  logic [1:0]  id_memtoreg;
  logic        id_alusrc1;
  logic        id_alusrc2;
  logic [3:0]  id_aluop;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm_ext;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;

  // Registered instruction presented to EX
  logic [1:0]  ex_pcsrc;
  logic        ex_regwrite;
  logic [1:0]  ex_regdst;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [1:0]  ex_memtoreg;
  logic        ex_alusrc1;
  logic        ex_alusrc2;
  logic [3:0]  ex_aluop;
  logic [31:0] ex_pc_plus4;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm_ext;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_shamt;
  logic [5:0]  ex_funct;
  logic        ex_valid;

  // ID side: drives the decoded instruction and pipeline controls
  modport master (
    output hold, flush,
    output id_pcsrc, id_regwrite, id_regdst, id_memread, id_memwrite,
    output id_memtoreg, id_alusrc1, id_alusrc2, id_aluop,
    output id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
    output id_rs, id_rt, id_rd, id_shamt, id_funct,
    input  stall,
    input  ex_pcsrc, ex_regwrite, ex_regdst, ex_memread, ex_memwrite,
    input  ex_memtoreg, ex_alusrc1, ex_alusrc2, ex_aluop,
    input  ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
    input  ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct, ex_valid
  );

  // Pipeline register side
  modport slave (
    input  hold, flush,
    input  id_pcsrc, id_regwrite, id_regdst, id_memread, id_memwrite,
    input  id_memtoreg, id_alusrc1, id_alusrc2, id_aluop,
    input  id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
    input  id_rs, id_rt, id_rd, id_shamt, id_funct,
    output stall,
    output ex_pcsrc, ex_regwrite, ex_regdst, ex_memread, ex_memwrite,
    output ex_memtoreg, ex_alusrc1, ex_alusrc2, ex_aluop,
    output ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
    output ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct, ex_valid
  );

endinterface
`default_nettype wire

// File: rtl/id_ex_register.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_register
//  Description : ID/EX pipeline register with load-use hazard detection,
//                bubble insertion on hazard or flush, hold support and a
//                remembered flush that is applied once the hold releases.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_register (
  input  logic            clk,
  input  logic            reset,
  id_ex_register_if.slave bus
);

  // Total width of the instruction payload carried from ID to EX:
  // 15 control bits + 4 x 32 data + 4 x 5 register/shamt + 6 funct.
  localparam int unsigned PAYLOAD_W = 169;

  logic [PAYLOAD_W-1:0] id_payload;
  logic [PAYLOAD_W-1:0] ex_payload_d;
  logic [PAYLOAD_W-1:0] ex_payload_q;
  logic                 ex_valid_d;
  logic                 ex_valid_q;
  logic                 flush_pending_d;
  logic                 flush_pending_q;
  logic                 flush_eff;
  logic                 hazard;

  // Pack the incoming instruction so it can be captured or zeroed as a whole
  assign id_payload = {bus.id_pcsrc, bus.id_regwrite, bus.id_regdst,
                       bus.id_memread, bus.id_memwrite, bus.id_memtoreg,
                       bus.id_alusrc1, bus.id_alusrc2, bus.id_aluop,
                       bus.id_pc_plus4, bus.id_rs_data, bus.id_rt_data,
                       bus.id_imm_ext, bus.id_rs, bus.id_rt, bus.id_rd,
                       bus.id_shamt, bus.id_funct};

  // Unpack the registered instruction onto the EX-side fields
  assign {bus.ex_pcsrc, bus.ex_regwrite, bus.ex_regdst,
          bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg,
          bus.ex_alusrc1, bus.ex_alusrc2, bus.ex_aluop,
          bus.ex_pc_plus4, bus.ex_rs_data, bus.ex_rt_data,
          bus.ex_imm_ext, bus.ex_rs, bus.ex_rt, bus.ex_rd,
          bus.ex_shamt, bus.ex_funct} = ex_payload_q;

  assign bus.ex_valid = ex_valid_q;

  // A flush seen while held still squashes the ID instruction later on
  assign flush_eff = bus.flush | flush_pending_q;

  // Load in EX whose destination is read by the instruction in ID. The rt
  // comparison is deliberately conservative (it applies to every opcode),
  // and $0 never creates a dependency.
  assign hazard = ex_valid_q & bus.ex_memread & (bus.ex_rt != 5'd0) &
                  ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));

  // Freeze PC and IF/ID; a flush discards the dependent instruction so no
  // stall is needed, and reset forces the stall low.
  assign bus.stall = ~reset & (bus.hold | (hazard & ~flush_eff));

  // Next-state selection: hold, then flush, then hazard bubble, then load
  always_comb begin
    ex_payload_d    = ex_payload_q;
    ex_valid_d      = ex_valid_q;
    flush_pending_d = flush_pending_q;
    if (bus.hold) begin
      flush_pending_d = flush_pending_q | bus.flush;
    end else if (flush_eff) begin
      ex_payload_d    = '0;
      ex_valid_d      = 1'b0;
      flush_pending_d = 1'b0;
    end else if (hazard) begin
      ex_payload_d    = '0;
      ex_valid_d      = 1'b0;
    end else begin
      ex_payload_d    = id_payload;
      ex_valid_d      = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_payload_q    <= '0;
      ex_valid_q      <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      ex_payload_q    <= ex_payload_d;
      ex_valid_q      <= ex_valid_d;
      flush_pending_q <= flush_pending_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_register
//  Description : Scoreboard testbench for id_ex_register. A driver issues
//                directed and random stimulus and pushes the expected EX
//                contents and stall into a queue; a monitor pops and compares
//                on every falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_register;

  typedef struct packed {
    logic [1:0]  pcsrc;
    logic        regwrite;
    logic [1:0]  regdst;
    logic        memread;
    logic        memwrite;
    logic [1:0]  memtoreg;
    logic        alusrc1;
    logic        alusrc2;
    logic [3:0]  aluop;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
  } instr_t;

  typedef struct {
    instr_t ex;
    logic   valid;
    logic   stall;
  } exp_t;

  logic clk;
  logic reset;

  id_ex_register_if bus ();

  id_ex_register dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed EX-side instruction, assembled from the named outputs
  instr_t act_ex;
  assign act_ex = {bus.ex_pcsrc, bus.ex_regwrite, bus.ex_regdst,
                   bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg,
                   bus.ex_alusrc1, bus.ex_alusrc2, bus.ex_aluop,
                   bus.ex_pc_plus4, bus.ex_rs_data, bus.ex_rt_data,
                   bus.ex_imm_ext, bus.ex_rs, bus.ex_rt, bus.ex_rd,
                   bus.ex_shamt, bus.ex_funct};

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;

  // Reference model: what EX should hold, and whether a flush is owed
  instr_t m_ex      = '0;
  logic   m_valid   = 1'b0;
  logic   m_owed    = 1'b0;
  logic   last_stall = 1'b0;

  task automatic set_id(input instr_t i);
    bus.id_pcsrc    = i.pcsrc;
    bus.id_regwrite = i.regwrite;
    bus.id_regdst   = i.regdst;
    bus.id_memread  = i.memread;
    bus.id_memwrite = i.memwrite;
    bus.id_memtoreg = i.memtoreg;
    bus.id_alusrc1  = i.alusrc1;
    bus.id_alusrc2  = i.alusrc2;
    bus.id_aluop    = i.aluop;
    bus.id_pc_plus4 = i.pc_plus4;
    bus.id_rs_data  = i.rs_data;
    bus.id_rt_data  = i.rt_data;
    bus.id_imm_ext  = i.imm_ext;
    bus.id_rs       = i.rs;
    bus.id_rt       = i.rt;
    bus.id_rd       = i.rd;
    bus.id_shamt    = i.shamt;
    bus.id_funct    = i.funct;
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i.pcsrc    = 2'($urandom_range(0, 3));
    i.regwrite = 1'($urandom_range(0, 1));
    i.regdst   = 2'($urandom_range(0, 3));
    i.memread  = 1'($urandom_range(0, 1));
    i.memwrite = 1'($urandom_range(0, 1));
    i.memtoreg = 2'($urandom_range(0, 3));
    i.alusrc1  = 1'($urandom_range(0, 1));
    i.alusrc2  = 1'($urandom_range(0, 1));
    i.aluop    = 4'($urandom_range(0, 15));
    i.pc_plus4 = $urandom;
    i.rs_data  = $urandom;
    i.rt_data  = $urandom;
    i.imm_ext  = $urandom;
    // Small register range so load-use dependencies occur often
    i.rs       = 5'($urandom_range(0, 7));
    i.rt       = 5'($urandom_range(0, 7));
    i.rd       = 5'($urandom_range(0, 31));
    i.shamt    = 5'($urandom_range(0, 31));
    i.funct    = 6'($urandom_range(0, 63));
    return i;
  endfunction

  // One clock of stimulus: present inputs just after the edge, record what
  // the DUT must show during this cycle, then advance the model
  task automatic step(input logic r, input logic h, input logic f, input instr_t ins);
    logic  load_use;
    logic  squash;
    logic  want_stall;
    exp_t  e;
    @(posedge clk);
    #1;
    reset     = r;
    bus.hold  = h;
    bus.flush = f;
    set_id(ins);

    squash     = f || m_owed;
    load_use   = m_valid && m_ex.memread && (m_ex.rt != 5'd0) &&
                 ((m_ex.rt == ins.rs) || (m_ex.rt == ins.rt));
    want_stall = !r && (h || (load_use && !squash));

    e.ex    = m_ex;
    e.valid = m_valid;
    e.stall = want_stall;
    exp_q.push_back(e);
    last_stall = want_stall;

    if (r) begin
      m_ex    = '0;
      m_valid = 1'b0;
      m_owed  = 1'b0;
    end else if (h) begin
      m_owed  = m_owed || f;
    end else if (squash || load_use) begin
      m_ex    = '0;
      m_valid = 1'b0;
      m_owed  = 1'b0;
    end else begin
      m_ex    = ins;
      m_valid = 1'b1;
    end
  endtask

  // Monitor: compare every cycle's outputs against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act_ex !== e.ex) begin
          errors++;
          $display("FAIL ex_fields @%0t: got %h expected %h", $time, act_ex, e.ex);
        end
        checks++;
        if (bus.ex_valid !== e.valid) begin
          errors++;
          $display("FAIL ex_valid @%0t: got %b expected %b", $time, bus.ex_valid, e.valid);
        end
        checks++;
        if (bus.stall !== e.stall) begin
          errors++;
          $display("FAIL stall @%0t: got %b expected %b", $time, bus.stall, e.stall);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Driver
  initial begin
    instr_t z, a, lw, dep, lw0, dep0, ins, prev;
    reset     = 1'b1;
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    z         = '0;
    set_id(z);

    // Reset then idle
    step(1, 0, 0, z);
    step(1, 0, 0, z);
    step(0, 0, 0, z);
    step(0, 0, 0, z);

    // Pass-through
    a          = '0;
    a.rs_data  = 32'h1234_5678;
    a.aluop    = 4'b0111;
    a.regwrite = 1'b1;
    a.rs       = 5'd1;
    a.rt       = 5'd2;
    step(0, 0, 0, a);
    step(0, 0, 0, z);

    // Load-use on rt = 5: one stall, one bubble, then the dependent loads
    lw          = '0;
    lw.memread  = 1'b1;
    lw.regwrite = 1'b1;
    lw.memtoreg = 2'd1;
    lw.rs       = 5'd3;
    lw.rt       = 5'd5;
    lw.imm_ext  = 32'h0000_0010;
    dep          = '0;
    dep.rs       = 5'd5;
    dep.rt       = 5'd7;
    dep.rd       = 5'd9;
    dep.regwrite = 1'b1;
    dep.aluop    = 4'd2;
    dep.rs_data  = 32'hCAFE_0001;
    step(0, 0, 0, lw);
    step(0, 0, 0, dep);
    step(0, 0, 0, dep);
    step(0, 0, 0, z);

    // Same with $0 as the load destination: no stall, no bubble
    lw0     = lw;
    lw0.rt  = 5'd0;
    dep0    = dep;
    dep0.rs = 5'd0;
    step(0, 0, 0, lw0);
    step(0, 0, 0, dep0);
    step(0, 0, 0, z);

    // Flush beats hazard
    step(0, 0, 0, lw);
    step(0, 0, 1, dep);
    step(0, 0, 0, a);
    step(0, 0, 0, z);

    // Flush during a 3-cycle hold, applied on the first unheld edge
    step(0, 0, 0, a);
    step(0, 1, 0, dep);
    step(0, 1, 1, dep);
    step(0, 1, 0, dep);
    step(0, 0, 0, dep);
    step(0, 0, 0, z);

    // Same, with reset in the third hold cycle discarding the pending flush
    step(0, 0, 0, a);
    step(0, 1, 0, dep);
    step(0, 1, 1, dep);
    step(1, 1, 0, dep);
    step(0, 0, 0, dep);
    step(0, 0, 0, z);

    // Random traffic; a stalled instruction stays in ID
    prev = z;
    for (int n = 0; n < 2000; n++) begin
      logic r, h, f;
      r = ($urandom_range(0, 49) == 0);
      h = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 6) == 0);
      ins = (last_stall && !r) ? prev : rand_instr();
      step(r, h, f, ins);
      prev = ins;
    end

    // Drain the scoreboard
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register of the five-stage pipelined MIPS CPU. Captures the decoded control fields produced by the instruction decoder, plus register operands, immediate and addressing fields, for consumption by the EX stage one cycle later. It also contains the load-use hazard detector, inserts bubbles on hazard or flush, and holds its contents on a downstream hold. A flush that arrives during a hold is remembered and applied afterwards.

## Interface
- No parameters. Data width is fixed at 32; register addresses are fixed at 5 bits.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- hold  in  1  downstream hold (e.g. memory wait); freezes this register.
- flush  in  1  taken branch or jump resolved in EX; the instruction now in ID is squashed.
- id_pcsrc[1:0], id_regwrite, id_regdst[1:0], id_memread, id_memwrite, id_memtoreg[1:0], id_alusrc1, id_alusrc2, id_aluop[3:0]  in  as named  decoder control fields.
- id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext  in  32 each  PC+4, operands and extended/LUI-shifted immediate.
- id_rs, id_rt, id_rd, id_shamt  in  5 each; id_funct  in  6.
- ex_* outputs  out  same widths as the matching id_* inputs  registered copies.
- ex_valid  out  1  1 = real instruction; 0 = bubble.
- stall  out  1  freezes the PC and the IF/ID register this cycle (combinational).

## Operation
- Effective flush: flush_eff = flush OR flush_pending.
- Hazard: hazard = ex_valid AND ex_memread AND (ex_rt != 0) AND (ex_rt == id_rs OR ex_rt == id_rt). The rt comparison is conservative and applies for every opcode.
- stall = hold OR (hazard AND NOT flush_eff). This is purely combinational from the inputs and the registered ex_* fields.
- Per-edge update, highest priority first:
  1. reset: all ex_* fields = 0, ex_valid = 0, flush_pending = 0.
  2. hold: all ex_* fields and ex_valid are unchanged. flush_pending <= flush_pending OR flush.
  3. flush_eff: load a bubble. flush_pending <= 0.
  4. hazard: load a bubble. The ID instruction stays in IF/ID because stall = 1.
  5. Otherwise: load all id_* fields into ex_*, set ex_valid = 1.
- Bubble: every ex_* control and data field = 0 and ex_valid = 0. This guarantees regwrite = memread = memwrite = 0 and pcsrc = 0.
- Reset value of every output: 0. This includes stall, since hold is treated as 0 when reset is asserted.
- A hazard is never raised against a bubble, because the condition is gated by ex_valid.
- Register $0 as ex_rt never raises a hazard.

## Timing
- Latency: exactly one cycle from id_* to ex_* when no hold, flush or hazard is present.
- Load-use: exactly one bubble per dependent instruction.
  - Cycle N: hazard, stall = 1, bubble loaded.
  - Cycle N+1: ex_valid = 0, so the hazard clears and the dependent instruction loads.
- Flush asserted with a hazard in the same cycle: the flush wins and stall = 0. Fetch proceeds to the branch target.
- Flush during hold:
  - Recorded in flush_pending on every held edge.
  - On the first unheld edge a bubble is loaded, even if flush has already deasserted.
  - flush_pending clears on that same edge.
- Reset asserted mid-hold or with flush_pending = 1: the register is cleared next edge and the pending flush is discarded.
- Hold is released and a hazard is present in the same cycle: a bubble is loaded and stall stays 1 for that cycle.

## Test plan
- Reset then idle: reset = 1 for 2 cycles, then 0 with all inputs 0 -> all ex_* = 0, ex_valid = 0, stall = 0 throughout reset.
- Pass-through: id_rs_data = 32'h1234_5678, id_aluop = 4'b0111, id_regwrite = 1, no hazard -> next cycle ex_rs_data = 32'h1234_5678, ex_aluop = 7, ex_valid = 1.
- Load-use: lw with rt = 5 in EX (ex_memread = 1), ID instruction with rs = 5 -> stall = 1 for exactly one cycle, then a bubble (ex_valid = 0, ex_regwrite = 0). The next edge loads the dependent instruction. Repeat with rt = 0 -> stall = 0 and no bubble.
- Flush beats hazard: the load-use setup above plus flush = 1 in the same cycle -> stall = 0, bubble loaded, no second bubble.
- Flush during hold: hold = 1 for 3 cycles, flush = 1 only in the 2nd -> ex_* unchanged for 3 edges, stall = 1. On the first unheld edge a bubble is loaded with flush already 0. Same scenario with reset in the 3rd hold cycle -> cleared and no extra bubble afterwards.
